sid_bus_sequencer: RTL and testbench

SID_BUS_SEQUENCER -- requirements
Module: sid_bus_sequencer

---
 rtl/sid_bus_sequencer.sv | 150 +++++++++++++++
 tb/tb_sid_bus_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sid_bus_sequencer.sv
// Host-side sequencer for a SID chip: queues register writes in a FIFO, runs one
// bus transaction per 4-clk phi2 period, and returns reads in order behind earlier writes.
module sid_bus_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       wr_stb,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       rd_stb,
   input  logic [4:0] rd_addr,
   input  logic       clr_ovf,
   input  logic [7:0] sid_d_in,
   output logic       sid_clk,
   output logic       sid_cs_n,
   output logic       sid_rw,
   output logic [4:0] sid_a,
   output logic [7:0] sid_d_out,
   output logic       sid_d_oe,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       busy,
   output logic       fifo_full,
   output logic       ovf
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

   state_t        state, state_n;
   logic [1:0]    ph;
   logic [12:0]   mem [0:DEPTH-1];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   count, count_n, wa;
   logic [4:0]    rd_a;
   logic          rd_pend, rd_pend_n;
   logic          sel, sel_rd, pop, push, rd_done, cs_on, cs_off, go_idle, rd_acc, drop;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_n;
   end

   // Work selection happens at the end of each SID cycle (ph==3), either from IDLE
   // or straight out of STROBE so transactions run back-to-back.
   always_comb begin
      state_n = state;
      sel     = 1'b0;
      sel_rd  = 1'b0;
      pop     = 1'b0;
      rd_done = 1'b0;
      cs_on   = 1'b0;
      cs_off  = 1'b0;
      go_idle = 1'b0;
      unique case (state)
         SETUP: if (ph == 2'd1) begin
            cs_on   = 1'b1;
            state_n = STROBE;
         end
         STROBE: if (ph == 2'd3) begin
            cs_off  = 1'b1;
            rd_done = sid_rw;
            sel     = 1'b1;
         end
         default: sel = (ph == 2'd3);
      endcase
      if (sel) begin
         // The read finishing this edge must not be picked again.
         if (rd_pend && !rd_done && wa == '0) begin
            sel_rd  = 1'b1;
            state_n = SETUP;
         end else if (count != '0) begin
            pop     = 1'b1;
            state_n = SETUP;
         end else begin
            go_idle = 1'b1;
            state_n = IDLE;
         end
      end
   end

   assign push      = wr_stb && (count != FULL || pop);
   assign rd_acc    = rd_stb && !rd_pend;
   assign drop      = (wr_stb && !push) || (rd_stb && rd_pend);
   assign count_n   = count + (AW+1)'(push) - (AW+1)'(pop);
   assign rd_pend_n = rd_acc || (rd_pend && !rd_done);
   assign sid_clk   = ph[1];

   // Same-edge push into a full FIFO reuses the slot being popped; the pop reads the old value.
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= {wr_addr, wr_data};
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ph        <= '0;
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         wa        <= '0;
         rd_pend   <= 1'b0;
         rd_a      <= '0;
         sid_cs_n  <= 1'b1;
         sid_rw    <= 1'b1;
         sid_d_oe  <= 1'b0;
         sid_a     <= '0;
         sid_d_out <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         ovf       <= 1'b0;
         busy      <= 1'b0;
         fifo_full <= 1'b0;
      end else begin
         ph      <= ph + 2'd1;
         count   <= count_n;
         rd_pend <= rd_pend_n;
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         // writes_ahead snapshots the queue depth so the read lands behind every earlier write.
         if (rd_acc) begin
            rd_a <= rd_addr;
            wa   <= count_n;
         end else if (rd_pend && pop) begin
            wa <= wa - 1'b1;
         end
         if (drop)         ovf <= 1'b1;
         else if (clr_ovf) ovf <= 1'b0;
         rd_valid <= rd_done;
         if (rd_done) rd_data <= sid_d_in;
         if (cs_on)       sid_cs_n <= 1'b0;
         else if (cs_off) sid_cs_n <= 1'b1;
         if (pop) begin
            {sid_a, sid_d_out} <= mem[rp];
            sid_rw             <= 1'b0;
            sid_d_oe           <= 1'b1;
         end else if (sel_rd) begin
            sid_a    <= rd_a;
            sid_rw   <= 1'b1;
            sid_d_oe <= 1'b0;
         end else if (go_idle) begin
            sid_rw   <= 1'b1;
            sid_d_oe <= 1'b0;
         end
         fifo_full <= (count_n == FULL);
         busy      <= (count_n != '0) || rd_pend_n || (state_n != IDLE);
      end
   end
endmodule

// File: tb/tb_sid_bus_sequencer.sv
// Directed bench for sid_bus_sequencer: expected bus cycles and read data are queued
// as requests are driven and checked as the SID bus and rd_valid report them.
module tb_sid_bus_sequencer;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic       rw;
      logic [4:0] a;
      logic [7:0] d;
   } bus_t;

   logic       clk = 1'b0, n_rst = 1'b0;
   logic       wr_stb = 1'b0, rd_stb = 1'b0, clr_ovf = 1'b0;
   logic [4:0] wr_addr = '0, rd_addr = '0;
   logic [7:0] wr_data = '0, sid_d_in = '0;
   logic       sid_clk, sid_cs_n, sid_rw, sid_d_oe, rd_valid, busy, fifo_full, ovf;
   logic [4:0] sid_a;
   logic [7:0] sid_d_out, rd_data;

   int   total = 0, bad = 0;
   bus_t exp_bus[$];
   logic [7:0] exp_rd[$];
   int   cyc_cnt = 0, last_fall = -1, falls = 0, low_run = 0, falls0 = 0, n = 0;
   logic prev_cs = 1'b1, prev_vld = 1'b0;

   sid_bus_sequencer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .n_rst(n_rst), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_stb(rd_stb), .rd_addr(rd_addr), .clr_ovf(clr_ovf), .sid_d_in(sid_d_in),
      .sid_clk(sid_clk), .sid_cs_n(sid_cs_n), .sid_rw(sid_rw), .sid_a(sid_a),
      .sid_d_out(sid_d_out), .sid_d_oe(sid_d_oe), .rd_data(rd_data), .rd_valid(rd_valid),
      .busy(busy), .fifo_full(fifo_full), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic bus_t mk(input logic rw, input logic [4:0] a, input logic [7:0] d);
      bus_t b;
      b.rw = rw; b.a = a; b.d = d;
      return b;
   endfunction

   // One clock of stimulus: inputs set before the call are seen by exactly one posedge.
   task automatic cyc();
      @(negedge clk);
      wr_stb = 1'b0; rd_stb = 1'b0; clr_ovf = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d, input bit acc);
      wr_stb = 1'b1; wr_addr = a; wr_data = d;
      if (acc) exp_bus.push_back(mk(1'b0, a, d));
   endtask

   task automatic rd(input logic [4:0] a, input logic [7:0] d, input bit acc);
      rd_stb = 1'b1; rd_addr = a;
      if (acc) begin
         exp_bus.push_back(mk(1'b1, a, 8'h00));
         exp_rd.push_back(d);
      end
   endtask

   // Returns at a negedge with reset just released; the next posedge sees ph==0.
   task automatic do_reset();
      @(negedge clk);
      n_rst = 1'b0; wr_stb = 1'b0; rd_stb = 1'b0; clr_ovf = 1'b0;
      #1;
      chk("rst_cs_n", sid_cs_n, 1);
      chk("rst_rw", sid_rw, 1);
      chk("rst_oe", sid_d_oe, 0);
      chk("rst_a", sid_a, 0);
      chk("rst_dout", sid_d_out, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_busy", busy, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_sid_clk", sid_clk, 0);
      exp_bus.delete(); exp_rd.delete();
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic wait_drain(input string tag);
      n = 0;
      while ((exp_bus.size() != 0 || exp_rd.size() != 0 || busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, (exp_bus.size() == 0 && exp_rd.size() == 0 && !busy), 1);
   endtask

   task automatic monitor();
      bus_t e;
      forever begin
         @(negedge clk);
         cyc_cnt++;
         if (!n_rst) begin
            prev_cs = 1'b1; prev_vld = 1'b0; low_run = 0; last_fall = -1;
         end else begin
            if (!sid_cs_n) begin
               chk("cs_in_phi2", sid_clk, 1);
               low_run++;
            end else if (low_run != 0) begin
               chk("cs_width", low_run, 2);
               low_run = 0;
            end
            if (prev_cs && !sid_cs_n) begin
               falls++;
               chk("bus_expected", exp_bus.size() != 0, 1);
               if (exp_bus.size() != 0) begin
                  e = exp_bus.pop_front();
                  chk("bus_rw", sid_rw, e.rw);
                  chk("bus_a", sid_a, e.a);
                  chk("bus_oe", sid_d_oe, !e.rw);
                  if (!e.rw) chk("bus_d", sid_d_out, e.d);
               end
               if (last_fall >= 0) chk("bus_spacing", cyc_cnt - last_fall, 4);
               last_fall = cyc_cnt;
            end
            if (rd_valid) begin
               chk("rd_valid_1clk", prev_vld, 0);
               chk("rd_expected", exp_rd.size() != 0, 1);
               if (exp_rd.size() != 0) chk("rd_data", rd_data, exp_rd.pop_front());
            end
            prev_cs  = sid_cs_n;
            prev_vld = rd_valid;
         end
      end
   endtask

   initial begin
      fork monitor(); join_none

      // single write; sid_clk follows ph[1] with ph==k+1 after edge k
      do_reset();
      wr(5'h18, 8'h0F, 1); cyc();
      chk("single_busy", busy, 1);
      for (int k = 0; k < 8; k++) begin
         chk("sid_clk_phase", sid_clk, ((k + 1) % 4) >= 2);
         cyc();
      end
      wait_drain("single_drain");
      chk("idle_oe", sid_d_oe, 0);
      chk("idle_rw", sid_rw, 1);
      chk("idle_a_hold", sid_a, 5'h18);
      chk("idle_d_hold", sid_d_out, 8'h0F);

      // burst of 6: the 4th edge pops, so 5 fit and the 6th is dropped
      do_reset();
      for (int i = 0; i < 6; i++) begin
         wr(5'(i + 1), 8'(8'h40 + i), i < 5); cyc();
         if (i == 4) chk("burst_full", fifo_full, 1);
      end
      chk("burst_ovf", ovf, 1);
      wait_drain("burst_drain");
      chk("burst_not_full", fifo_full, 0);

      // read ordered behind two earlier writes
      do_reset();
      sid_d_in = 8'hA5;
      wr(5'h01, 8'h11, 1); cyc();
      wr(5'h02, 8'h22, 1); cyc();
      rd(5'h1B, 8'hA5, 1); cyc();
      wait_drain("read_drain");

      // same-clk write and read on empty FIFO: write goes first
      do_reset();
      sid_d_in = 8'h3C;
      wr(5'h05, 8'h55, 1); rd(5'h06, 8'h3C, 1); cyc();
      wait_drain("simul_drain");

      // reset during STROBE
      do_reset();
      wr(5'h0A, 8'hAA, 1); cyc();
      wr(5'h0B, 8'hBB, 0); cyc();
      n = 0;
      while (sid_cs_n && n < 40) begin @(negedge clk); n++; end
      @(negedge clk);
      chk("mid_cs_low", sid_cs_n, 0);
      n_rst = 1'b0;
      #1;
      chk("mid_rst_cs_n", sid_cs_n, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_oe", sid_d_oe, 0);
      exp_bus.delete(); exp_rd.delete();
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      falls0 = falls;
      repeat (24) @(negedge clk);
      chk("mid_no_cycles", falls - falls0, 0);
      chk("mid_idle_busy", busy, 0);

      // ovf: set, clear-with-drop keeps it, clear alone clears, read drop sets
      do_reset();
      sid_d_in = 8'h77;
      for (int i = 0; i < 5; i++) begin
         wr(5'(i + 8), 8'(8'h80 + i), 1); cyc();
      end
      chk("ovf_pre", ovf, 0);
      wr(5'h1F, 8'hEE, 0); cyc();
      chk("ovf_set", ovf, 1);
      wr(5'h1E, 8'hDD, 0); clr_ovf = 1'b1; cyc();
      chk("ovf_set_wins", ovf, 1);
      clr_ovf = 1'b1; cyc();
      chk("ovf_clr", ovf, 0);
      rd(5'h0C, 8'h77, 1); cyc();
      chk("ovf_rd_ok", ovf, 0);
      rd(5'h0D, 8'h00, 0); cyc();
      chk("ovf_rd_drop", ovf, 1);
      wait_drain("ovf_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
